// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline plus the mult/div busy sequencer.
// Optional stall statistics counter is enabled by defining STALL_STATS_EN.
module stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_WriteReg,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_WriteReg,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_clear,
  output logic        md_busy,
`ifdef STALL_STATS_EN
  output logic        md_done,
  output logic [31:0] stall_count
`else
  output logic        md_done
`endif
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t  state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       rs_stall, rt_stall, md_stall, stall;

  // The youngest producer (E) shadows M when both write the same register.
  function automatic logic src_stall(input logic [4:0] addr, input logic [1:0] tuse,
                                     input logic [4:0] e_wr, input logic [1:0] e_tn,
                                     input logic [4:0] m_wr, input logic [1:0] m_tn);
    logic r;
    r = 1'b0;
    if (addr != 5'd0) begin
      if (addr == e_wr)      r = (tuse < e_tn);
      else if (addr == m_wr) r = (tuse < m_tn);
    end
    return r;
  endfunction

  always_comb begin
    rs_stall = src_stall(d_rs_addr, d_tuse_rs, e_WriteReg, e_tnew, m_WriteReg, m_tnew);
    rt_stall = src_stall(d_rt_addr, d_tuse_rt, e_WriteReg, e_tnew, m_WriteReg, m_tnew);
    md_stall = d_is_md && (md_busy || e_md_start);
    stall    = rs_stall || rt_stall || md_stall;
    pc_en      = !stall;
    ifid_en    = !stall;
    idex_clear = stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A start seen while BUSY is deliberately dropped; no reload.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (e_md_start) begin
          cnt_next   = e_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = IDLE;
      end
      default: begin
        cnt_next   = 4'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    md_busy = (cnt != 4'd0);
    md_done = (cnt == 4'd1);
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)      stall_count <= 32'd0;
    else if (stall) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: combinational hazard table plus
// multi-cycle mult/div sequencing, ignored restart, mid-op reset and stats counter.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_WriteReg, m_WriteReg;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        pc_en, ifid_en, idex_clear, md_busy, md_done;
`ifdef STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_is_md(d_is_md),
    .e_WriteReg(e_WriteReg), .e_tnew(e_tnew),
    .m_WriteReg(m_WriteReg), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_clear(idex_clear),
    .md_busy(md_busy),
`ifdef STALL_STATS_EN
    .md_done(md_done),
    .stall_count(stall_count)
`else
    .md_done(md_done)
`endif
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       is_md;
    logic [4:0] e_wr;
    logic [1:0] e_tn;
    logic [4:0] m_wr;
    logic [1:0] m_tn;
    logic       stall;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    d_rs_addr = 0; d_rt_addr = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 0;
    e_WriteReg = 0; e_tnew = 0; m_WriteReg = 0; m_tnew = 0;
    e_md_start = 0; e_md_is_div = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    d_rs_addr = v.rs; d_rt_addr = v.rt; d_tuse_rs = v.tuse_rs; d_tuse_rt = v.tuse_rt;
    d_is_md = v.is_md; e_WriteReg = v.e_wr; e_tnew = v.e_tn;
    m_WriteReg = v.m_wr; m_tnew = v.m_tn; e_md_start = 0; e_md_is_div = 0;
    #1;
  endtask

  task automatic checkStallOuts(input string name, input logic exp_stall);
    checkOutput(name, {29'd0, pc_en, ifid_en, idex_clear}, {29'd0, !exp_stall, !exp_stall, exp_stall});
  endtask

  initial begin
    //            rs  rt  trs trt md  ewr etn mwr mtn stall
    vecs[0]  = '{ 0,  0,  3,  3,  0,  0,  0,  0,  0,  0 };  // idle
    vecs[1]  = '{ 8,  0,  1,  3,  0,  8,  2,  0,  0,  1 };  // load-use
    vecs[2]  = '{ 8,  0,  1,  3,  0,  8,  1,  0,  0,  0 };  // result ready in time
    vecs[3]  = '{ 0,  0,  0,  3,  0,  0,  2,  0,  0,  0 };  // $0 never stalls
    vecs[4]  = '{ 8,  0,  3,  3,  0,  8,  2,  0,  0,  0 };  // rs not read
    vecs[5]  = '{ 0,  9,  3,  0,  0,  0,  0,  9,  1,  1 };  // rt vs M
    vecs[6]  = '{ 0,  9,  3,  1,  0,  0,  0,  9,  1,  0 };  // rt vs M, in time
    vecs[7]  = '{ 5,  0,  1,  3,  0,  5,  1,  5,  2,  0 };  // E shadows M
    vecs[8]  = '{ 5,  0,  0,  3,  0,  5,  1,  5,  0,  1 };  // E hazard
    vecs[9]  = '{ 0,  0,  3,  3,  1,  0,  0,  0,  0,  0 };  // md instr, unit idle
    vecs[10] = '{ 4,  0,  0,  3,  0,  7,  2,  0,  0,  0 };  // address mismatch
    vecs[11] = '{ 0, 31,  3,  0,  0, 31,  3,  0,  0,  1 };  // rt vs E, tnew 3

    clearInputs();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_md_busy", {31'd0, md_busy}, 32'd0);
    checkOutput("reset_md_done", {31'd0, md_done}, 32'd0);
    checkStallOuts("reset_stall_outs", 1'b0);
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkStallOuts($sformatf("vec%0d", i), vecs[i].stall);
    end
    @(negedge clk);
    clearInputs();

    // Mult with dependent D instruction, then back-to-back restart.
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 0; d_is_md = 1;
    #1;
    checkStallOuts("mult_start_stall", 1'b1);
    checkOutput("mult_start_busy", {31'd0, md_busy}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e_md_start = 0;
      #1;
      checkOutput($sformatf("mult_busy_k%0d", k), {31'd0, md_busy}, {31'd0, k <= 5});
      checkOutput($sformatf("mult_done_k%0d", k), {31'd0, md_done}, {31'd0, k == 5});
      checkStallOuts($sformatf("mult_stall_k%0d", k), k <= 5);
    end
    d_is_md = 0; e_md_start = 1; e_md_is_div = 0;
    @(negedge clk);
    e_md_start = 0;
    #1;
    checkOutput("b2b_busy", {31'd0, md_busy}, 32'd1);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("b2b_idle", {31'd0, md_busy}, 32'd0);

    // Div with a restart attempt that must be ignored.
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      e_md_start = (k == 3);
      e_md_is_div = (k == 3) ? 1'b0 : 1'b1;
      #1;
      checkOutput($sformatf("div_busy_k%0d", k), {31'd0, md_busy}, {31'd0, k <= 10});
      checkOutput($sformatf("div_done_k%0d", k), {31'd0, md_done}, {31'd0, k == 10});
    end
    clearInputs();

    // Reset in the middle of a divide.
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e_md_start = 0;
      #1;
      checkOutput($sformatf("rdiv_busy_k%0d", k), {31'd0, md_busy}, 32'd1);
    end
    reset = 1;
    @(negedge clk);
    #1;
    checkOutput("rdiv_md_busy", {31'd0, md_busy}, 32'd0);
    checkOutput("rdiv_md_done", {31'd0, md_done}, 32'd0);
    checkStallOuts("rdiv_stall_outs", 1'b0);
    reset = 0;

`ifdef STALL_STATS_EN
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    checkOutput("stats_reset", stall_count, 32'd0);
    reset = 0;
    d_rs_addr = 8; d_tuse_rs = 1; e_WriteReg = 8; e_tnew = 2;
    repeat (3) @(negedge clk);
    clearInputs();
    e_md_start = 1; e_md_is_div = 0; d_is_md = 1;
    @(negedge clk);
    e_md_start = 0;
    repeat (5) @(negedge clk);
    d_is_md = 0;
    #1;
    checkOutput("stats_count", stall_count, 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
